// File: rtl/snake_render_pkg.sv
// Shared constants, state encoding and snapshot payload for the snake renderer.
package snake_render_pkg;

  localparam int unsigned GRID    = 16;
  localparam int unsigned SEG_W   = 8;
  localparam int unsigned MAX_SEG = 10;
  localparam int unsigned COORD_W = 4;
  localparam int unsigned SNAKE_W = SEG_W * MAX_SEG;
  localparam int unsigned IDX_W   = 11;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    DRAW  = 3'd2,
    FOOD  = 3'd3,
    SWAP  = 3'd4
  } state_e;

  // One captured frame request: body, segment count and food position.
  typedef struct packed {
    logic [SNAKE_W-1:0] snake;
    logic [CNT_W-1:0]   nseg;
    logic [COORD_W-1:0] xfood;
    logic [COORD_W-1:0] yfood;
  } snap_t;

  // Head MSB position must be 8n-1 for n = 1..MAX_SEG.
  function automatic logic index_ok(input logic [IDX_W-1:0] idx);
    return (idx >= IDX_W'(SEG_W - 1)) && (idx <= IDX_W'(SNAKE_W - 1)) &&
           (idx[2:0] == 3'b111);
  endfunction

  // Segment count n = (index + 1) / 8.
  function automatic logic [CNT_W-1:0] seg_count(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] p1;
    p1 = idx + IDX_W'(1);
    return CNT_W'(p1 >> 3);
  endfunction

endpackage

// File: rtl/snake_render_if.sv
// Request/display bus between a frame producer and the snake renderer.
interface snake_render_if;
  import snake_render_pkg::*;

  logic [SNAKE_W-1:0] snake;
  logic               write_snake;
  logic [IDX_W-1:0]   index;
  logic [COORD_W-1:0] xfood;
  logic [COORD_W-1:0] yfood;
  logic [COORD_W-1:0] row_sel;
  logic [GRID-1:0]    row_data;
  logic               frame_valid;
  logic               busy;
  logic               self_hit;
  logic               bad_index;

  modport master (
    output snake, write_snake, index, xfood, yfood, row_sel,
    input  row_data, frame_valid, busy, self_hit, bad_index
  );

  modport slave (
    input  snake, write_snake, index, xfood, yfood, row_sel,
    output row_data, frame_valid, busy, self_hit, bad_index
  );

endinterface

// File: rtl/snake_fb.sv
// 16x16 double frame buffer: drawing touches only the back, display reads only the front.
module snake_fb
  import snake_render_pkg::*;
(
  input  logic               slw_clk,
  input  logic               reset,
  input  logic               we_i,
  input  logic [COORD_W-1:0] wr_row_i,
  input  logic [GRID-1:0]    wr_data_i,
  input  logic [COORD_W-1:0] back_row_i,
  output logic [GRID-1:0]    back_data_c_o,
  input  logic [COORD_W-1:0] front_row_i,
  output logic [GRID-1:0]    front_data_o,
  input  logic               swap_i
);

  logic [1:0][GRID-1:0][GRID-1:0] buf_q;
  logic                           front_sel_q;
  logic                           back_sel_c;
  logic [GRID-1:0]                front_data_q;

  assign back_sel_c    = ~front_sel_q;
  assign back_data_c_o = buf_q[back_sel_c][back_row_i];
  assign front_data_o  = front_data_q;

  // Back-buffer row write, buffer swap, and registered front read that follows a swap at once.
  always_ff @(posedge slw_clk) begin
    if (reset) begin
      buf_q        <= '0;
      front_sel_q  <= 1'b0;
      front_data_q <= '0;
    end else begin
      if (we_i) begin
        buf_q[back_sel_c][wr_row_i] <= wr_data_i;
      end
      if (swap_i) begin
        front_sel_q  <= back_sel_c;
        front_data_q <= buf_q[back_sel_c][front_row_i];
      end else begin
        front_data_q <= buf_q[front_sel_q][front_row_i];
      end
    end
  end

endmodule

// File: rtl/snake_render.sv
// Snake frame renderer: captures a body snapshot, redraws the back buffer, swaps it to the front.
module snake_render
  import snake_render_pkg::*;
(
  input  logic           slw_clk,
  input  logic           reset,
  snake_render_if.slave  bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  snap_t              snap_q, snap_d;
  snap_t              pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic               pend_ok_q, pend_ok_d;
  logic               hit_next_q, hit_next_d;
  logic               self_hit_q, self_hit_d;
  logic               frame_valid_q, frame_valid_d;
  logic               bad_index_q, bad_index_d;
  logic               busy_q, busy_d;

  snap_t              in_snap_c;
  logic               in_ok_c;
  snap_t              cand_c;
  logic               cand_vld_c;
  logic               cand_ok_c;
  logic [SEG_W-1:0]   seg_c;
  logic [COORD_W-1:0] seg_x_c;
  logic [COORD_W-1:0] seg_y_c;

  logic               fb_we_c;
  logic [COORD_W-1:0] fb_wr_row_c;
  logic [GRID-1:0]    fb_wr_data_c;
  logic [COORD_W-1:0] fb_back_row_c;
  logic [GRID-1:0]    fb_back_data_c;
  logic               fb_swap_c;
  logic [GRID-1:0]    row_data_w;

  // Incoming snapshot as presented on the bus this cycle.
  always_comb begin
    in_snap_c.snake = bus.snake;
    in_snap_c.nseg  = seg_count(bus.index);
    in_snap_c.xfood = bus.xfood;
    in_snap_c.yfood = bus.yfood;
    in_ok_c         = index_ok(bus.index);
  end

  // Segment currently being drawn.
  always_comb begin
    seg_c   = SEG_W'(snap_q.snake >> (7'(cnt_q) * 7'(SEG_W)));
    seg_x_c = seg_c[COORD_W-1:0];
    seg_y_c = seg_c[SEG_W-1:COORD_W];
  end

  // Next-state, buffer port control and pending-slot management.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    snap_d        = snap_q;
    pend_d        = pend_q;
    pend_vld_d    = pend_vld_q;
    pend_ok_d     = pend_ok_q;
    hit_next_d    = hit_next_q;
    self_hit_d    = self_hit_q;
    frame_valid_d = 1'b0;
    bad_index_d   = 1'b0;
    fb_we_c       = 1'b0;
    fb_wr_row_c   = cnt_q;
    fb_wr_data_c  = '0;
    fb_back_row_c = (state_q == FOOD) ? snap_q.yfood : seg_y_c;
    fb_swap_c     = 1'b0;
    cand_c        = pend_q;
    cand_vld_c    = 1'b0;
    cand_ok_c     = 1'b0;

    // Strobes mid-frame park in the one-deep slot; the newest wins.
    if (bus.write_snake && (state_q != IDLE) && (state_q != SWAP)) begin
      pend_d     = in_snap_c;
      pend_ok_d  = in_ok_c;
      pend_vld_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.write_snake) begin
          if (in_ok_c) begin
            snap_d  = in_snap_c;
            cnt_d   = '0;
            state_d = CLEAR;
          end else begin
            bad_index_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        fb_we_c      = 1'b1;
        fb_wr_row_c  = cnt_q;
        fb_wr_data_c = '0;
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(GRID - 1)) begin
          cnt_d   = '0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        fb_we_c      = 1'b1;
        fb_wr_row_c  = seg_y_c;
        fb_wr_data_c = fb_back_data_c | GRID'(GRID'(1) << seg_x_c);
        if (cnt_q == CNT_W'(snap_q.nseg - CNT_W'(1))) begin
          hit_next_d = fb_back_data_c[seg_x_c];
          cnt_d      = '0;
          state_d    = FOOD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FOOD: begin
        fb_we_c      = 1'b1;
        fb_wr_row_c  = snap_q.yfood;
        fb_wr_data_c = fb_back_data_c | GRID'(GRID'(1) << snap_q.xfood);
        state_d      = SWAP;
      end
      SWAP: begin
        fb_swap_c     = 1'b1;
        frame_valid_d = 1'b1;
        self_hit_d    = hit_next_q;
        state_d       = IDLE;
        // A strobe on this very edge is newer than anything parked.
        if (bus.write_snake) begin
          cand_c     = in_snap_c;
          cand_ok_c  = in_ok_c;
          cand_vld_c = 1'b1;
        end else if (pend_vld_q) begin
          cand_c     = pend_q;
          cand_ok_c  = pend_ok_q;
          cand_vld_c = 1'b1;
        end
        pend_vld_d = 1'b0;
        if (cand_vld_c) begin
          if (cand_ok_c) begin
            snap_d  = cand_c;
            cnt_d   = '0;
            state_d = CLEAR;
          end else begin
            bad_index_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge slw_clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      snap_q        <= '0;
      pend_q        <= '0;
      pend_vld_q    <= 1'b0;
      pend_ok_q     <= 1'b0;
      hit_next_q    <= 1'b0;
      self_hit_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      bad_index_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      snap_q        <= snap_d;
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
      pend_ok_q     <= pend_ok_d;
      hit_next_q    <= hit_next_d;
      self_hit_q    <= self_hit_d;
      frame_valid_q <= frame_valid_d;
      bad_index_q   <= bad_index_d;
      busy_q        <= busy_d;
    end
  end

  snake_fb u_fb (
    .slw_clk       (slw_clk),
    .reset         (reset),
    .we_i          (fb_we_c),
    .wr_row_i      (fb_wr_row_c),
    .wr_data_i     (fb_wr_data_c),
    .back_row_i    (fb_back_row_c),
    .back_data_c_o (fb_back_data_c),
    .front_row_i   (bus.row_sel),
    .front_data_o  (row_data_w),
    .swap_i        (fb_swap_c)
  );

  assign bus.row_data    = row_data_w;
  assign bus.frame_valid = frame_valid_q;
  assign bus.busy        = busy_q;
  assign bus.self_hit    = self_hit_q;
  assign bus.bad_index   = bad_index_q;

endmodule

// File: tb/tb_snake_render.sv
// Directed bench for snake_render with hand-computed frame contents.
module tb_snake_render;

  logic slw_clk = 1'b0;
  logic reset   = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  snake_render_if bus ();

  snake_render dut (
    .slw_clk (slw_clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  always #5 slw_clk = ~slw_clk;

  task automatic tick();
    @(posedge slw_clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic read_row(input int r, output logic [15:0] d);
    bus.row_sel = 4'(r);
    tick();
    d = bus.row_data;
  endtask

  task automatic start_frame(input logic [79:0] s, input logic [10:0] idx,
                             input logic [3:0] xf, input logic [3:0] yf);
    bus.snake       = s;
    bus.index       = idx;
    bus.xfood       = xf;
    bus.yfood       = yf;
    bus.write_snake = 1'b1;
    tick();
    bus.write_snake = 1'b0;
  endtask

  // Cycles from the capturing edge until frame_valid, bounded.
  task automatic wait_frame(output int cyc);
    cyc = 0;
    while (!bus.frame_valid && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic check_rows(input string tag, input logic [15:0] exp [16]);
    logic [15:0] d;
    for (int r = 0; r < 16; r++) begin
      read_row(r, d);
      check_eq($sformatf("%s_row%0d", tag, r), 32'(d), 32'(exp[r]));
    end
  endtask

  initial begin
    int          cyc;
    int          pulses;
    int          first_t;
    int          second_t;
    logic        busy_at_first;
    logic [15:0] d;
    logic [15:0] exp_rows [16];
    logic [10:0] bad_idx [4];

    bus.snake       = '0;
    bus.write_snake = 1'b0;
    bus.index       = '0;
    bus.xfood       = '0;
    bus.yfood       = '0;
    bus.row_sel     = '0;

    // Reset state
    repeat (3) tick();
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
    check_eq("rst_self_hit", 32'(bus.self_hit), 32'd0);
    check_eq("rst_bad_index", 32'(bus.bad_index), 32'd0);
    check_eq("rst_row_data", 32'(bus.row_data), 32'd0);
    reset = 1'b0;
    tick();

    // Three-segment snake along row 1, food at (3,3)
    bus.row_sel = 4'd1;
    start_frame(80'h131211, 11'd23, 4'd3, 4'd3);
    check_eq("f1_busy", 32'(bus.busy), 32'd1);
    wait_frame(cyc);
    check_eq("f1_latency", 32'(cyc), 32'd21);
    check_eq("f1_row_on_swap", 32'(bus.row_data), 32'h000E);
    check_eq("f1_self_hit", 32'(bus.self_hit), 32'd0);
    tick();
    check_eq("f1_pulse_width", 32'(bus.frame_valid), 32'd0);
    check_eq("f1_busy_after", 32'(bus.busy), 32'd0);
    foreach (exp_rows[i]) exp_rows[i] = 16'h0000;
    exp_rows[1] = 16'h000E;
    exp_rows[3] = 16'h0008;
    check_rows("f1", exp_rows);

    // Rejected indices
    bad_idx[0] = 11'd20;
    bad_idx[1] = 11'd87;
    bad_idx[2] = 11'd3;
    bad_idx[3] = 11'd80;
    for (int i = 0; i < 4; i++) begin
      bus.index       = bad_idx[i];
      bus.write_snake = 1'b1;
      tick();
      bus.write_snake = 1'b0;
      check_eq($sformatf("bad%0d_pulse", i), 32'(bus.bad_index), 32'd1);
      check_eq($sformatf("bad%0d_busy", i), 32'(bus.busy), 32'd0);
      tick();
      check_eq($sformatf("bad%0d_pulse_end", i), 32'(bus.bad_index), 32'd0);
      check_eq($sformatf("bad%0d_busy_idle", i), 32'(bus.busy), 32'd0);
    end
    read_row(1, d);
    check_eq("bad_front_row1", 32'(d), 32'h000E);
    read_row(3, d);
    check_eq("bad_front_row3", 32'(d), 32'h0008);

    // Head 0x22 lands on the tail pixel (2,2)
    start_frame(80'h2232332322, 11'd39, 4'd15, 4'd0);
    wait_frame(cyc);
    check_eq("hit_latency", 32'(cyc), 32'd23);
    check_eq("hit_self_hit", 32'(bus.self_hit), 32'd1);
    tick();
    foreach (exp_rows[i]) exp_rows[i] = 16'h0000;
    exp_rows[0] = 16'h8000;
    exp_rows[2] = 16'h000C;
    exp_rows[3] = 16'h000C;
    check_rows("hit", exp_rows);
    check_eq("hit_self_hit_hold", 32'(bus.self_hit), 32'd1);

    // Two strobes during DRAW: second one must win and chain with no idle gap
    pulses        = 0;
    first_t       = 0;
    second_t      = 0;
    busy_at_first = 1'b0;
    start_frame(80'h59585756555453525150, 11'd79, 4'd0, 4'd0);
    for (int t = 1; t <= 100; t++) begin
      bus.write_snake = (t == 18) || (t == 20);
      bus.xfood       = (t == 18) ? 4'd7 : 4'd9;
      bus.yfood       = (t == 18) ? 4'd7 : 4'd9;
      tick();
      bus.write_snake = 1'b0;
      if (bus.frame_valid) begin
        pulses++;
        if (pulses == 1) begin
          first_t       = t;
          busy_at_first = bus.busy;
        end else if (pulses == 2) begin
          second_t = t;
        end
      end
    end
    check_eq("pend_pulses", 32'(pulses), 32'd2);
    check_eq("pend_first_t", 32'(first_t), 32'd28);
    check_eq("pend_second_t", 32'(second_t), 32'd56);
    check_eq("pend_busy_no_drop", 32'(busy_at_first), 32'd1);
    check_eq("pend_self_hit", 32'(bus.self_hit), 32'd0);
    foreach (exp_rows[i]) exp_rows[i] = 16'h0000;
    exp_rows[5] = 16'h03FF;
    exp_rows[9] = 16'h0200;
    check_rows("pend", exp_rows);

    // Invalid snapshot parked mid-frame is rejected at the swap
    start_frame(80'h131211, 11'd23, 4'd3, 4'd3);
    repeat (4) tick();
    bus.index       = 11'd20;
    bus.write_snake = 1'b1;
    tick();
    bus.write_snake = 1'b0;
    wait_frame(cyc);
    check_eq("pbad_latency", 32'(cyc), 32'd16);
    check_eq("pbad_bad_index", 32'(bus.bad_index), 32'd1);
    check_eq("pbad_busy", 32'(bus.busy), 32'd0);

    // Ten segments on row 0, food in the far corner
    start_frame(80'h09080706050403020100, 11'd79, 4'd15, 4'd15);
    wait_frame(cyc);
    check_eq("max_latency", 32'(cyc), 32'd28);
    tick();
    read_row(15, d);
    check_eq("max_row15", 32'(d), 32'h8000);
    read_row(0, d);
    check_eq("max_row0", 32'(d), 32'h03FF);

    // Reset during CLEAR aborts the frame and wipes both buffers
    start_frame(80'h131211, 11'd23, 4'd3, 4'd3);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_frame_valid", 32'(bus.frame_valid), 32'd0);
    pulses = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (bus.frame_valid) pulses++;
    end
    check_eq("abort_pulses", 32'(pulses), 32'd0);
    foreach (exp_rows[i]) exp_rows[i] = 16'h0000;
    check_rows("abort", exp_rows);

    // Reset wins over a coincident strobe
    bus.index       = 11'd23;
    bus.write_snake = 1'b1;
    reset           = 1'b1;
    tick();
    reset           = 1'b0;
    bus.write_snake = 1'b0;
    check_eq("rstpri_busy", 32'(bus.busy), 32'd0);
    tick();
    check_eq("rstpri_busy_next", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
